forth_loader: RTL and testbench
===============================

// Module: forth_loader
// PURPOSE
//  Boot/debug sequencer for the forth core. Consumes a host byte stream (valid/ready), writes
//  program words into instruction RAM while holding the core in reset, then releases it.
//  Sits between the host UART and the core's reset and instruction/data RAM ports; owns cpu_reset.
// PARAMETERS
//  WIDTH        16  data word width (core data width)
//  IADDR_WIDTH  10  instruction RAM address width
//  DADDR_WIDTH   8  data RAM address width
// PORTS
//  clk          in   1            clock
//  reset_n      in   1            asynchronous active-low reset
//  rx_data      in   8            host byte
//  rx_valid     in   1            rx_data valid
//  rx_ready     out  1            byte accepted when rx_valid & rx_ready
//  tx_data      out  8            reply byte
//  tx_valid     out  1            reply valid; held with tx_data stable until tx_ready
//  tx_ready     in   1            host took reply
//  cpu_reset    out  1            core reset (active-high, to core reset input)
//  imem_waddr   out  IADDR_WIDTH  instruction RAM write address
//  imem_wdata   out  16           instruction RAM write data
//  imem_we      out  1            instruction RAM write strobe (1 cycle)
//  dmem_sel     out  1            1: dmem_addr overrides core daddr (peek only)
//  dmem_addr    out  DADDR_WIDTH  data RAM address while dmem_sel
//  dmem_rdata   in   WIDTH        data RAM read data, valid 1 cycle after address
// BEHAVIOUR
//  Reset: cpu_reset=1, rx_ready=1, tx_valid=0, imem_we=0, dmem_sel=0, other outs 0, state IDLE.
//  Commands (first byte in IDLE): 'L'=0x4C load, 'R'=0x52 run, 'H'=0x48 halt; others dropped.
//  'R': cpu_reset<=0 next cycle, no reply. 'H': cpu_reset<=1 next cycle, no reply.
//  'L': cpu_reset<=1 immediately (stays 1 after load); then HDR takes 4 bytes: addr_lo, addr_hi,
//   cnt_lo, cnt_hi (addr truncated to IADDR_WIDTH; cnt 16-bit words). cnt==0 -> straight to ACK.
//  DATA_LO/DATA_HI: word = {hi,lo}. After hi accepted -> WRITE: imem_we=1 one cycle with
//   waddr=addr, wdata=word; addr+1 (wraps mod 2^IADDR_WIDTH), cnt-1; cnt==0 -> ACK else DATA_LO.
//  ACK: tx_data=0x06, tx_valid=1 until tx_ready, then IDLE.
//  States: IDLE, HDR, DATA_LO, DATA_HI, WRITE, ACK (+PEEK_A, PEEK_RD, PEEK_LO, PEEK_HI).
//  rx_ready=1 only in IDLE, HDR, DATA_LO, DATA_HI, PEEK_A; 0 in WRITE/ACK/PEEK_RD/PEEK_LO/HI.
//  Throughput: one word per 3 cycles min (lo, hi, write). No timeout: stall on rx_valid=0 indefinitely.
//  tx back-pressure: FSM waits in ACK/PEEK_* while tx_valid & !tx_ready; no reply dropped.
//  reset_n low mid-load: all state cleared, partial load abandoned, cpu_reset=1.
// CONFIGURATION
//  FORTH_LOADER_PEEK_EN defined: 'P'=0x50 then 1 addr byte. If cpu_reset==1: PEEK_RD drives
//   dmem_sel=1, dmem_addr=byte for 1 cycle, captures dmem_rdata next cycle, replies lo then hi
//   byte. If core running: single reply 0x15 (NAK), dmem_sel stays 0.
//  Undefined: 'P' is an unknown command (dropped, no reply); dmem_sel tied 0, dmem_addr tied 0.
// STRUCTURE
//  forth_pkg: command codes (CMD_LOAD/RUN/HALT/PEEK), ACK=0x06, NAK=0x15, loader state enum.
//  Sub-module forth_tx_slot: single-entry reply holding register (load/valid/ready); FSM in top.
// TESTING
//  Post-reset: cpu_reset=1, tx_valid=0, imem_we=0; send 'R' -> cpu_reset=0 next cycle.
//  'L',0x10,0x00,0x02,0x00,0x34,0x12,0x78,0x56 -> writes 0x1234@0x010, 0x5678@0x011, one ACK 0x06.
//  Load addr 0x3FF cnt 2 -> writes at 0x3FF then 0x000 (wrap); cnt 0 -> ACK only, no imem_we.
//  'L' while running -> cpu_reset=1 at once, remains 1 after ACK; tx_ready low 20 cycles -> ACK held.
//  reset_n pulsed after 3 data bytes -> IDLE, no further imem_we, cpu_reset=1.
//  PEEK_EN: halted, 'P',0x05 with dmem[5]=0xBEEF -> 0xEF,0xBE; running -> 0x15; without macro -> silent.

Source files
------------

// File: rtl/forth_pkg.sv
// Shared definitions for the forth boot/debug loader: host command codes,
// reply codes, the loader state encoding and a receive-window helper.
package forth_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_HALT = 8'h48;
  localparam logic [7:0] CMD_PEEK = 8'h50;
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_HDR     = 4'd1,
    ST_DATA_LO = 4'd2,
    ST_DATA_HI = 4'd3,
    ST_WRITE   = 4'd4,
    ST_ACK     = 4'd5,
    ST_PEEK_A  = 4'd6,
    ST_PEEK_RD = 4'd7,
    ST_PEEK_LO = 4'd8,
    ST_PEEK_HI = 4'd9
  } loader_state_t;

  // States in which the loader is willing to take a host byte.
  function automatic logic rx_open(input loader_state_t st);
    case (st)
      ST_IDLE, ST_HDR, ST_DATA_LO, ST_DATA_HI, ST_PEEK_A: rx_open = 1'b1;
      default:                                           rx_open = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/forth_tx_slot.sv
// Single-entry reply holding register. A byte loaded here is presented on
// tx_data/tx_valid and held stable until the host raises tx_ready.
module forth_tx_slot (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] load_data,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);

  logic [7:0] data_r;
  logic       valid_r;

  // Capture a reply on load; release the slot once the host has taken it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_r  <= 8'h00;
      valid_r <= 1'b0;
    end else if (load) begin
      data_r  <= load_data;
      valid_r <= 1'b1;
    end else if (valid_r && tx_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign tx_data  = data_r;
  assign tx_valid = valid_r;

endmodule

// File: rtl/forth_loader.sv
// Boot/debug sequencer for the forth core. Parses host commands, writes
// program words into instruction RAM while the core is held in reset and
// controls the core reset line.
// Optional data-RAM peek command is built when FORTH_LOADER_PEEK_EN is defined.
module forth_loader
  import forth_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int IADDR_WIDTH = 10,
  parameter int DADDR_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   cpu_reset,
  output logic [IADDR_WIDTH-1:0] imem_waddr,
  output logic [15:0]            imem_wdata,
  output logic                   imem_we,
  output logic                   dmem_sel,
  output logic [DADDR_WIDTH-1:0] dmem_addr,
  input  logic [WIDTH-1:0]       dmem_rdata
);

  loader_state_t          state_r, state_s;
  logic [IADDR_WIDTH-1:0] addr_r, addr_s;
  logic [15:0]            cnt_r, cnt_s;
  logic [1:0]             hdr_idx_r, hdr_idx_s;
  logic [7:0]             lo_byte_r, lo_byte_s;
  logic                   cpu_reset_r, cpu_reset_s;
  logic                   rx_ready_r;
  logic                   imem_we_r;
  logic [IADDR_WIDTH-1:0] imem_waddr_r;
  logic [15:0]            imem_wdata_r;
  logic                   wr_load_s;
  logic                   tx_load_s;
  logic [7:0]             tx_load_data_s;
  logic                   rx_fire_s;
  logic                   tx_done_s;
  logic [15:0]            word_s;
  logic                   unused_rdata_s;

  assign rx_fire_s      = rx_valid & rx_ready_r;
  assign tx_done_s      = tx_valid & tx_ready;
  // Header fields and data words are little-endian byte pairs.
  assign word_s         = {rx_data, lo_byte_r};
  assign unused_rdata_s = ^dmem_rdata;

`ifdef FORTH_LOADER_PEEK_EN
  logic                   peek_pend_r, peek_pend_s;
  logic [7:0]             peek_hi_r, peek_hi_s;
  logic                   dmem_sel_r;
  logic [DADDR_WIDTH-1:0] dmem_addr_r, peek_addr_s;
`endif

  // Next-state and datapath decode for the command parser.
  always_comb begin
    state_s        = state_r;
    addr_s         = addr_r;
    cnt_s          = cnt_r;
    hdr_idx_s      = hdr_idx_r;
    lo_byte_s      = lo_byte_r;
    cpu_reset_s    = cpu_reset_r;
    wr_load_s      = 1'b0;
    tx_load_s      = 1'b0;
    tx_load_data_s = 8'h00;
`ifdef FORTH_LOADER_PEEK_EN
    peek_pend_s    = peek_pend_r;
    peek_hi_s      = peek_hi_r;
    peek_addr_s    = dmem_addr_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (rx_fire_s) begin
          case (rx_data)
            CMD_LOAD: begin
              cpu_reset_s = 1'b1;
              hdr_idx_s   = 2'd0;
              state_s     = ST_HDR;
            end
            CMD_RUN:  cpu_reset_s = 1'b0;
            CMD_HALT: cpu_reset_s = 1'b1;
`ifdef FORTH_LOADER_PEEK_EN
            CMD_PEEK: state_s = ST_PEEK_A;
`endif
            default:  state_s = ST_IDLE;
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (rx_fire_s) begin
          hdr_idx_s = hdr_idx_r + 2'd1;
          case (hdr_idx_r)
            2'd0: lo_byte_s = rx_data;
            2'd1: addr_s = word_s[IADDR_WIDTH-1:0];
            2'd2: lo_byte_s = rx_data;
            default: begin
              cnt_s = word_s;
              if (word_s == 16'd0) begin
                state_s        = ST_ACK;
                tx_load_s      = 1'b1;
                tx_load_data_s = ACK_BYTE;
              end else begin
                state_s = ST_DATA_LO;
              end
            end
          endcase
        end else begin
          hdr_idx_s = hdr_idx_r;
        end
      end
      ST_DATA_LO: begin
        if (rx_fire_s) begin
          lo_byte_s = rx_data;
          state_s   = ST_DATA_HI;
        end else begin
          state_s = ST_DATA_LO;
        end
      end
      ST_DATA_HI: begin
        if (rx_fire_s) begin
          wr_load_s = 1'b1;
          state_s   = ST_WRITE;
        end else begin
          state_s = ST_DATA_HI;
        end
      end
      ST_WRITE: begin
        addr_s = addr_r + {{(IADDR_WIDTH-1){1'b0}}, 1'b1};
        cnt_s  = cnt_r - 16'd1;
        if (cnt_r == 16'd1) begin
          state_s        = ST_ACK;
          tx_load_s      = 1'b1;
          tx_load_data_s = ACK_BYTE;
        end else begin
          state_s = ST_DATA_LO;
        end
      end
      ST_ACK: begin
        if (tx_done_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_ACK;
        end
      end
`ifdef FORTH_LOADER_PEEK_EN
      ST_PEEK_A: begin
        if (rx_fire_s) begin
          if (cpu_reset_r) begin
            peek_addr_s = DADDR_WIDTH'(rx_data);
            state_s     = ST_PEEK_RD;
          end else begin
            // Core owns the data RAM while running: refuse instead of stealing the port.
            tx_load_s      = 1'b1;
            tx_load_data_s = NAK_BYTE;
            state_s        = ST_PEEK_HI;
          end
        end else begin
          state_s = ST_PEEK_A;
        end
      end
      ST_PEEK_RD: begin
        peek_pend_s = 1'b1;
        state_s     = ST_PEEK_LO;
      end
      ST_PEEK_LO: begin
        if (peek_pend_r) begin
          // Read data is valid in the cycle after the address was presented.
          peek_pend_s    = 1'b0;
          peek_hi_s      = dmem_rdata[15:8];
          tx_load_s      = 1'b1;
          tx_load_data_s = dmem_rdata[7:0];
        end else if (tx_done_s) begin
          tx_load_s      = 1'b1;
          tx_load_data_s = peek_hi_r;
          state_s        = ST_PEEK_HI;
        end else begin
          state_s = ST_PEEK_LO;
        end
      end
      ST_PEEK_HI: begin
        if (tx_done_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_PEEK_HI;
        end
      end
`endif
      default: state_s = ST_IDLE;
    endcase
  end

  // State, datapath and registered output update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      addr_r       <= '0;
      cnt_r        <= 16'd0;
      hdr_idx_r    <= 2'd0;
      lo_byte_r    <= 8'h00;
      cpu_reset_r  <= 1'b1;
      rx_ready_r   <= 1'b1;
      imem_we_r    <= 1'b0;
      imem_waddr_r <= '0;
      imem_wdata_r <= 16'h0000;
    end else begin
      state_r     <= state_s;
      addr_r      <= addr_s;
      cnt_r       <= cnt_s;
      hdr_idx_r   <= hdr_idx_s;
      lo_byte_r   <= lo_byte_s;
      cpu_reset_r <= cpu_reset_s;
      rx_ready_r  <= rx_open(state_s);
      imem_we_r   <= wr_load_s;
      if (wr_load_s) begin
        imem_waddr_r <= addr_r;
        imem_wdata_r <= word_s;
      end else begin
        imem_waddr_r <= imem_waddr_r;
        imem_wdata_r <= imem_wdata_r;
      end
    end
  end

`ifdef FORTH_LOADER_PEEK_EN
  // Peek bookkeeping and the data-RAM address override.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      peek_pend_r <= 1'b0;
      peek_hi_r   <= 8'h00;
      dmem_sel_r  <= 1'b0;
      dmem_addr_r <= '0;
    end else begin
      peek_pend_r <= peek_pend_s;
      peek_hi_r   <= peek_hi_s;
      dmem_sel_r  <= (state_s == ST_PEEK_RD);
      dmem_addr_r <= (state_s == ST_PEEK_RD) ? peek_addr_s : '0;
    end
  end

  assign dmem_sel  = dmem_sel_r;
  assign dmem_addr = dmem_addr_r;
`else
  assign dmem_sel  = 1'b0;
  assign dmem_addr = '0;
`endif

  forth_tx_slot u_tx_slot (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (tx_load_s),
    .load_data (tx_load_data_s),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
  );

  assign rx_ready   = rx_ready_r;
  assign cpu_reset  = cpu_reset_r;
  assign imem_we    = imem_we_r;
  assign imem_waddr = imem_waddr_r;
  assign imem_wdata = imem_wdata_r;

endmodule

// File: tb/tb_forth_loader.sv
// Self-checking bench for forth_loader: randomized command stream against a
// command-level reference model (expected RAM writes, replies, core reset).
module tb_forth_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        cpu_reset;
  logic [9:0]  imem_waddr;
  logic [15:0] imem_wdata;
  logic        imem_we;
  logic        dmem_sel;
  logic [7:0]  dmem_addr;
  logic [15:0] dmem_rdata = 16'h0000;

  int          n_tests = 0;
  int          n_fail = 0;
  bit          tx_hold = 1'b0;
  bit          model_cpu = 1'b1;
  bit [15:0]   dmem [256];
  bit [15:0]   ld_words [8];
  bit [31:0]   exp_wr [$];
  bit [31:0]   got_wr [$];
  bit [31:0]   exp_tx [$];
  bit [31:0]   got_tx [$];
  bit          prev_pending = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  forth_loader dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .cpu_reset  (cpu_reset),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .imem_we    (imem_we),
    .dmem_sel   (dmem_sel),
    .dmem_addr  (dmem_addr),
    .dmem_rdata (dmem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read data RAM seen by the loader's peek port.
  always @(posedge clk) dmem_rdata <= dmem[dmem_addr];

  task automatic check(input string tag, input bit [31:0] got, input bit [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Host side: drive tx_ready, record writes and taken replies, check reply hold.
  always @(negedge clk) begin
    tx_ready = tx_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    if (reset_n) begin
      if (prev_pending) check("tx_held", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, prev_data});
      if (imem_we) got_wr.push_back({6'd0, imem_waddr, imem_wdata});
      if (tx_valid && tx_ready) got_tx.push_back({24'd0, tx_data});
      prev_pending = tx_valid && !tx_ready;
      prev_data    = tx_data;
    end else begin
      prev_pending = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("rx_accept_timeout", 32'(n), 32'd0);
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic settle();
    int n = 0;
    while ((got_tx.size() < exp_tx.size() || got_wr.size() < exp_wr.size()) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("settle_timeout", 32'(n), 32'd0);
    repeat (4) @(negedge clk);
    check("wr_count", 32'(got_wr.size()), 32'(exp_wr.size()));
    check("tx_count", 32'(got_tx.size()), 32'(exp_tx.size()));
    while (exp_wr.size() > 0 && got_wr.size() > 0) check("imem_write", got_wr.pop_front(), exp_wr.pop_front());
    while (exp_tx.size() > 0 && got_tx.size() > 0) check("reply", got_tx.pop_front(), exp_tx.pop_front());
    exp_wr.delete(); got_wr.delete(); exp_tx.delete(); got_tx.delete();
    check("cpu_reset", 32'(cpu_reset), 32'(model_cpu));
    check("dmem_idle", {23'd0, dmem_sel, dmem_addr}, 32'd0);
  endtask

  task automatic cmd_run();
    send_byte(8'h52);
    check("run_cpu_reset", 32'(cpu_reset), 32'd0);
    model_cpu = 1'b0;
  endtask

  task automatic cmd_halt();
    send_byte(8'h48);
    check("halt_cpu_reset", 32'(cpu_reset), 32'd1);
    model_cpu = 1'b1;
  endtask

  // Load words into instruction RAM; the bytes of the last word sent are
  // limited to nbytes (0..2*cnt) so a load can be cut short.
  task automatic cmd_load(input int addr, input int cnt, input int nbytes);
    int sent = 0;
    send_byte(8'h4C);
    check("load_cpu_reset", 32'(cpu_reset), 32'd1);
    model_cpu = 1'b1;
    send_byte(addr[7:0]);
    send_byte(addr[15:8]);
    send_byte(cnt[7:0]);
    send_byte(cnt[15:8]);
    for (int i = 0; i < cnt && sent < nbytes; i++) begin
      send_byte(ld_words[i][7:0]);
      sent++;
      if (sent < nbytes) begin
        send_byte(ld_words[i][15:8]);
        sent++;
        exp_wr.push_back(32'((((addr % 1024) + i) % 1024) * 65536 + int'(ld_words[i])));
      end
    end
    if (nbytes >= 2 * cnt) exp_tx.push_back(32'h06);
  endtask

  task automatic cmd_peek(input int a);
    send_byte(8'h50);
    send_byte(a[7:0]);
`ifdef FORTH_LOADER_PEEK_EN
    if (model_cpu) begin
      exp_tx.push_back(32'(dmem[a] & 16'h00FF));
      exp_tx.push_back(32'(dmem[a] >> 8));
    end else begin
      exp_tx.push_back(32'h15);
    end
`endif
  endtask

  task automatic rand_words(input int cnt);
    for (int i = 0; i < cnt; i++) ld_words[i] = 16'($urandom);
  endtask

  initial begin
    int cnt;
    int junk;
    int n;
    for (int i = 0; i < 256; i++) dmem[i] = 16'($urandom);
    dmem[5] = 16'hBEEF;
    repeat (3) @(negedge clk);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_dmem_sel", 32'(dmem_sel), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    cmd_run();
    settle();

    ld_words[0] = 16'h1234;
    ld_words[1] = 16'h5678;
    cmd_load(16'h0010, 2, 4);
    settle();

    rand_words(2);
    cmd_load(16'h03FF, 2, 4);
    settle();

    cmd_load(16'h0123, 0, 0);
    settle();

    // Load while the core runs, with the host refusing the ACK for 20 cycles.
    cmd_run();
    settle();
    tx_hold = 1'b1;
    rand_words(3);
    cmd_load(16'h0200, 3, 6);
    n = 0;
    while (!tx_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    check("ack_held_valid", 32'(tx_valid), 32'd1);
    check("ack_held_data", 32'(tx_data), 32'h06);
    check("ack_held_cpu_reset", 32'(cpu_reset), 32'd1);
    tx_hold = 1'b0;
    settle();

    // Reset in the middle of a load abandons it.
    cmd_run();
    settle();
    rand_words(4);
    cmd_load(16'h0040, 4, 3);
    reset_n = 1'b0;
    model_cpu = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    settle();

    cmd_halt();
    cmd_peek(5);
    settle();
    cmd_run();
    cmd_peek(5);
    settle();

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 5))
        0: cmd_run();
        1: cmd_halt();
        2, 3: begin
          cnt = $urandom_range(0, 5);
          rand_words(cnt);
          cmd_load(int'($urandom_range(0, 65535)), cnt, 2 * cnt);
        end
        4: cmd_peek(int'($urandom_range(0, 63)));
        default: begin
          junk = int'($urandom_range(0, 255));
          while (junk == 8'h4C || junk == 8'h52 || junk == 8'h48 || junk == 8'h50)
            junk = int'($urandom_range(0, 255));
          send_byte(junk[7:0]);
        end
      endcase
      settle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
